// File: rtl/pong_pkg.sv
// Shared types and constants for the pong text-overlay game sequencer:
// state codes, text-region masks ({score, logo, rule, over}) and the BCD digit type.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [3:0] TEXT_EN_NEWGAME = 4'b1110;
    localparam logic [3:0] TEXT_EN_PLAY    = 4'b1100;
    localparam logic [3:0] TEXT_EN_OVER    = 4'b1101;

    typedef logic [3:0] bcd_digit_t;

    // NEWBALL shows the same regions as PLAY; only the ball freeze differs.
    function automatic logic [3:0] text_mask(state_t s);
        case (s)
            ST_NEWGAME: text_mask = TEXT_EN_NEWGAME;
            ST_OVER:    text_mask = TEXT_EN_OVER;
            default:    text_mask = TEXT_EN_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD incrementer: synchronous clear, increment enable, 99 -> 00 wrap.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] dig0,
    output logic [3:0] dig1
);

    bcd_digit_t dig0_reg;
    bcd_digit_t dig1_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig0_reg <= '0;
            dig1_reg <= '0;
        end else if (clr) begin
            dig0_reg <= '0;
            dig1_reg <= '0;
        end else if (inc) begin
            if (dig0_reg == 4'd9) begin
                dig0_reg <= '0;
                dig1_reg <= (dig1_reg == 4'd9) ? 4'd0 : dig1_reg + 4'd1;
            end else begin
                dig0_reg <= dig0_reg + 4'd1;
            end
        end
    end

    assign dig0 = dig0_reg;
    assign dig1 = dig1_reg;

endmodule

// File: rtl/pong_text_ctrl.sv
// Pong game sequencer: owns score, balls, game clock and text-region mask.
// Define PONG_GAME_TIMER_EN to build the game clock and time-out game end.
module pong_text_ctrl
    import pong_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int DELAY_FRAMES   = 120,
    parameter int GAME_SECONDS   = 99,
    parameter int NUM_BALLS      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic [6:0] timer,
    output logic [3:0] text_en,
    output logic       gra_still,
    output logic [1:0] state_o
);

    localparam int DELAY_W = $clog2(DELAY_FRAMES + 1);

    state_t               state_reg, state_next;
    logic [1:0]           ball_reg, ball_next;
    logic [DELAY_W-1:0]   delay_cnt_reg, delay_cnt_next;
    logic [3:0]           text_en_reg;
    logic                 gra_still_reg;
    logic                 delay_done;
    logic                 score_clr;
    logic                 score_inc;

`ifdef PONG_GAME_TIMER_EN
    localparam int SEC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    logic [SEC_W-1:0]     sec_cnt_reg, sec_cnt_next;
    logic [6:0]           timer_reg, timer_next;
`endif

    // Delay expires on the refr_tick that brings the count to DELAY_FRAMES, then stays expired.
    assign delay_done = (delay_cnt_reg == DELAY_W'(DELAY_FRAMES)) ||
                        (refr_tick && delay_cnt_reg == DELAY_W'(DELAY_FRAMES - 1));

    always_comb begin
        state_next     = state_reg;
        ball_next      = ball_reg;
        delay_cnt_next = delay_cnt_reg;
        score_clr      = 1'b0;
        score_inc      = 1'b0;
`ifdef PONG_GAME_TIMER_EN
        sec_cnt_next   = sec_cnt_reg;
        timer_next     = timer_reg;
`endif
        if (refr_tick && delay_cnt_reg != DELAY_W'(DELAY_FRAMES))
            delay_cnt_next = delay_cnt_reg + 1'b1;

        case (state_reg)
            ST_NEWGAME: begin
                if (btn != 2'b00) begin
                    state_next = ST_PLAY;
                    score_clr  = 1'b1;
                    ball_next  = 2'(NUM_BALLS);
`ifdef PONG_GAME_TIMER_EN
                    timer_next   = 7'(GAME_SECONDS);
                    sec_cnt_next = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    if (ball_reg == 2'd1) begin
                        ball_next  = 2'd0;
                        state_next = ST_OVER;
                    end else begin
                        ball_next  = ball_reg - 2'd1;
                        state_next = ST_NEWBALL;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
`ifdef PONG_GAME_TIMER_EN
                // Expiry overrides NEWBALL so a simultaneous miss still ends the game.
                if (refr_tick) begin
                    if (sec_cnt_reg == SEC_W'(FRAMES_PER_SEC - 1)) begin
                        sec_cnt_next = '0;
                        if (timer_reg != 7'd0)
                            timer_next = timer_reg - 7'd1;
                        if (timer_reg == 7'd1)
                            state_next = ST_OVER;
                    end else begin
                        sec_cnt_next = sec_cnt_reg + 1'b1;
                    end
                end
`endif
            end
            ST_NEWBALL: begin
                if (delay_done && btn != 2'b00)
                    state_next = ST_PLAY;
            end
            ST_OVER: begin
                if (delay_done)
                    state_next = ST_NEWGAME;
            end
            default: state_next = ST_NEWGAME;
        endcase

        if (state_next != state_reg)
            delay_cnt_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_NEWGAME;
            ball_reg      <= 2'(NUM_BALLS);
            delay_cnt_reg <= '0;
            text_en_reg   <= TEXT_EN_NEWGAME;
            gra_still_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            ball_reg      <= ball_next;
            delay_cnt_reg <= delay_cnt_next;
            text_en_reg   <= text_mask(state_next);
            gra_still_reg <= (state_next != ST_PLAY);
        end
    end

`ifdef PONG_GAME_TIMER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_cnt_reg <= '0;
            timer_reg   <= 7'(GAME_SECONDS);
        end else begin
            sec_cnt_reg <= sec_cnt_next;
            timer_reg   <= timer_next;
        end
    end
    assign timer = timer_reg;
`else
    assign timer = 7'd0;
`endif

    bcd2_counter u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (score_clr),
        .inc     (score_inc),
        .dig0    (dig0),
        .dig1    (dig1)
    );

    assign ball      = ball_reg;
    assign text_en   = text_en_reg;
    assign gra_still = gra_still_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_pong_text_ctrl.sv
// Directed self-checking bench for pong_text_ctrl (game clock shortened to 2 s x 4 frames).
module tb_pong_text_ctrl;

    localparam int GS  = 2;
    localparam int FPS = 4;
`ifdef PONG_GAME_TIMER_EN
    localparam int T0 = GS;
`else
    localparam int T0 = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic [3:0] dig0, dig1;
    logic [1:0] ball;
    logic [6:0] timer;
    logic [3:0] text_en;
    logic       gra_still;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pong_text_ctrl #(
        .FRAMES_PER_SEC (FPS),
        .DELAY_FRAMES   (120),
        .GAME_SECONDS   (GS),
        .NUM_BALLS      (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .refr_tick (refr_tick),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .dig0      (dig0),
        .dig1      (dig1),
        .ball      (ball),
        .timer     (timer),
        .text_en   (text_en),
        .gra_still (gra_still),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            refr_tick = 1'b1;
            cyc();
            refr_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            cyc();
            hit = 1'b0;
            cyc();
        end
    endtask

    task automatic press();
        btn = 2'b01;
        cyc();
        btn = 2'b00;
    endtask

    task automatic do_miss();
        miss = 1'b1;
        cyc();
        miss = 1'b0;
    endtask

    function automatic int score();
        return {24'd0, dig1, dig0};
    endfunction

    initial begin
        reset_n = 1'b0; refr_tick = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0;
        cyc(); cyc();
        check("rst_state", state_o, 0);
        check("rst_ball", ball, 3);
        check("rst_score", score(), 'h00);
        check("rst_timer", timer, T0);
        check("rst_text_en", text_en, 'b1110);
        check("rst_still", gra_still, 1);
        reset_n = 1'b1;
        cyc();
        check("idle_state", state_o, 0);

        // Start game
        press();
        check("start_state", state_o, 1);
        check("start_text_en", text_en, 'b1100);
        check("start_still", gra_still, 0);
        check("start_ball", ball, 3);
        check("start_score", score(), 'h00);
        check("start_timer", timer, T0);

        // BCD scoring
        hits(9);   check("score_09", score(), 'h09);
        hits(1);   check("score_10", score(), 'h10);
        hits(2);   check("score_12", score(), 'h12);
        hits(87);  check("score_99", score(), 'h99);
        hits(1);   check("score_wrap", score(), 'h00);

        // Miss -> NEWBALL, delay with btn held
        do_miss();
        check("nb_state", state_o, 2);
        check("nb_ball", ball, 2);
        check("nb_still", gra_still, 1);
        check("nb_text_en", text_en, 'b1100);
        btn = 2'b01;
        ticks(60);
        do_miss();
        check("nb_miss_ignored", ball, 2);
        hits(1);
        check("nb_hit_ignored", score(), 'h00);
        ticks(59);
        check("nb_119", state_o, 2);
        ticks(1);
        check("nb_120_play", state_o, 1);
        check("nb_120_still", gra_still, 0);
        btn = 2'b00;

        // Last ball: hit+miss together, then OVER delay
        hits(3);
        check("score_03", score(), 'h03);
        do_miss();
        check("nb2_ball", ball, 1);
        btn = 2'b01;
        ticks(120);
        check("nb2_play", state_o, 1);
        btn = 2'b00;
        hit = 1'b1; miss = 1'b1;
        cyc();
        hit = 1'b0; miss = 1'b0;
        check("over_state", state_o, 3);
        check("over_ball", ball, 0);
        check("over_text_en", text_en, 'b1101);
        check("over_score", score(), 'h03);
        btn = 2'b01;
        ticks(119);
        check("over_119", state_o, 3);
        btn = 2'b00;
        ticks(1);
        check("ng_state", state_o, 0);
        check("ng_text_en", text_en, 'b1110);
        check("ng_score_held", score(), 'h03);

        // Game clock
        press();
        check("g2_state", state_o, 1);
        check("g2_score", score(), 'h00);
        check("g2_ball", ball, 3);
        check("g2_timer", timer, T0);
        ticks(FPS);
`ifdef PONG_GAME_TIMER_EN
        check("tmr_1", timer, 1);
        check("tmr_1_state", state_o, 1);
        ticks(FPS);
        check("tmr_0", timer, 0);
        check("tmr_over", state_o, 3);
        check("tmr_ball", ball, 3);
        ticks(120);
        check("tmr_ng", state_o, 0);
        press();
        check("g3_state", state_o, 1);
`else
        ticks(FPS);
        check("tmr_off", timer, 0);
        check("tmr_off_state", state_o, 1);
`endif

        // Async reset in NEWBALL
        hits(1);
        do_miss();
        check("pre_rst_state", state_o, 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_state", state_o, 0);
        check("arst_ball", ball, 3);
        check("arst_score", score(), 'h00);
        check("arst_text_en", text_en, 'b1110);
        check("arst_still", gra_still, 1);
        #2;
        reset_n = 1'b1;
        cyc();
        press();
        check("post_rst_play", state_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
